// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and widths shared by the loader, instruction memory and fetch stage
package imem_loader_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int HDR_BYTES = 2;
  localparam int CHK_BYTES = 1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a length-prefixed, XOR-checked byte image into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int MEM_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);
  state_t state, nxt;
  logic [7:0] len_lo, lo, xr;
  logic [ADDR_WIDTH-1:0] wcnt, last;
  logic [15:0] n;
  logic acc, oversize, restart;
  assign in_ready = state inside {LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHK};
  assign acc = in_valid & in_ready;
  assign n = {in_byte, len_lo};
  assign oversize = 32'(n) > 32'(MEM_WORDS);
  assign restart = start & (state inside {IDLE, DONE, ERR});
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign error = state == ERR;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state decode; start only matters in IDLE and the terminal states
  always_comb begin
    nxt = state;
    case (state)
      LEN_LO: nxt = acc ? LEN_HI : state;
      LEN_HI: nxt = !acc ? state : oversize ? ERR : n == 16'd0 ? CHK : DAT_LO;
      DAT_LO: nxt = acc ? DAT_HI : state;
      DAT_HI: nxt = !acc ? state : wcnt == last ? CHK : DAT_LO;
      CHK:    nxt = !acc ? state : in_byte == xr ? DONE : ERR;
      default: nxt = restart ? LEN_LO : state;
    endcase
  end
  // byte assembly, running checksum and the registered memory write port
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len_lo <= '0;
      lo <= '0;
      xr <= '0;
      wcnt <= '0;
      last <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we <= 1'b0;
    end else begin
      mem_we <= acc && state == DAT_HI;
      if (restart) begin
        wcnt <= '0;
        xr <= '0;
      end else if (acc) begin
        if (state != CHK) xr <= xr ^ in_byte;
        if (state == LEN_LO) len_lo <= in_byte;
        if (state == LEN_HI) last <= ADDR_WIDTH'(n - 16'd1);
        if (state == DAT_LO) lo <= in_byte;
        if (state == DAT_HI) begin
          mem_addr <= wcnt;
          mem_data <= DATA_WIDTH'({in_byte, lo});
          wcnt <= wcnt + ADDR_WIDTH'(1);
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for the instruction memory loader
module tb_imem_loader;
  localparam int MW = 1024;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_ready, mem_we, cpu_hold, done, error;
  logic [15:0] mem_addr, mem_data;
  wr_t exp_q[$];
  int checks = 0, fails = 0, we_cnt = 0;
  bq_t nom, s;

  always #5 clk = ~clk;

  imem_loader #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest outstanding expected write
  always @(negedge clk)
    if (mem_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_data, w.data);
      end
    end

  // reference model: parse the image, queue its writes, return 1=done 2=bad checksum 3=oversize
  task automatic model(input bq_t b, output int res);
    int n;
    logic [7:0] x;
    n = {b[1], b[0]};
    if (n > MW) res = 3;
    else begin
      x = 8'h00;
      for (int i = 0; i < b.size() - 1; i++) x ^= b[i];
      for (int k = 0; k < n; k++) exp_q.push_back('{addr: 16'(k), data: {b[3 + 2 * k], b[2 + 2 * k]}});
      res = (b[b.size() - 1] == x) ? 1 : 2;
    end
  endtask

  task automatic make(input int n, input bit bad, output bq_t b);
    logic [7:0] x;
    b = {};
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    if (n <= MW) begin
      for (int k = 0; k < 2 * n; k++) b.push_back(8'($urandom));
      x = 8'h00;
      foreach (b[i]) x ^= b[i];
      b.push_back(bad ? x ^ 8'($urandom_range(1, 255)) : x);
    end
  endtask

  // called just after a falling edge; returns just after the falling edge following acceptance
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_byte = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input string nm, input bq_t b, input bit gaps, input bit mid);
    int res, ns, w0, n;
    model(b, res);
    n = {b[1], b[0]};
    ns = (res == 3) ? 2 : b.size();
    w0 = we_cnt;
    pulse_start();
    for (int i = 0; i < ns; i++) begin
      if (gaps) repeat ($urandom_range(0, 5)) @(negedge clk);
      if (mid && i == 3) pulse_start();
      send(b[i]);
    end
    chk({nm, "_done"}, done, res == 1);
    chk({nm, "_error"}, error, res != 1);
    chk({nm, "_cpu_hold"}, cpu_hold, res != 1);
    chk({nm, "_in_ready"}, in_ready, 0);
    @(negedge clk);
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_we_count"}, we_cnt - w0, (res == 3) ? 0 : n);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_data"}, mem_data, 0);
    chk({nm, "_mem_we"}, mem_we, 0);
    chk({nm, "_cpu_hold"}, cpu_hold, 1);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    nom = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
    run_load("nominal", nom, 0, 0);
    s = nom;
    s[6] = 8'h43;
    run_load("bad_chk", s, 0, 0);
    run_load("oversize", '{8'h01, 8'h04}, 0, 0);
    run_load("gaps_mid_start", nom, 1, 1);
    w0 = we_cnt;
    exp_q.delete();
    pulse_start();
    send(8'h02);
    send(8'h00);
    send(8'h34);
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    chk("rst_mid_no_we", we_cnt - w0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle_ready", in_ready, 0);
    run_load("after_rst", nom, 0, 0);
    run_load("empty", '{8'h00, 8'h00, 8'h00}, 0, 0);
    run_load("reload", nom, 0, 0);
    for (int r = 0; r < 12; r++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 2) make($urandom_range(MW + 1, 65535), 0, s);
      else if (kind == 3) make(0, $urandom_range(0, 1), s);
      else make($urandom_range(1, 8), kind == 1, s);
      run_load($sformatf("rand%0d", r), s, $urandom_range(0, 1), $urandom_range(0, 1));
    end
    make(MW, 0, s);
    run_load("max_len", s, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory. After a `start` pulse it accepts a byte stream over a valid/ready handshake, assembles little-endian 16-bit instruction words, and drives the instruction memory write port (`addr`, `data`, `we`) word by word. It holds the CPU in stall until the image is loaded and its checksum verifies, then releases it.

## Interface
- `DATA_WIDTH`, 16, instruction word width; must be 16.
- `ADDR_WIDTH`, 16, width of `mem_addr`, matching the instruction memory `addr` port.
- `MEM_WORDS`, 1024, capacity in words; a larger requested image is an error.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  ADDR_WIDTH  word address driven to the instruction memory `addr` port.
- `mem_data`  out  DATA_WIDTH  word driven to the instruction memory `data` port.
- `mem_we`  out  1  write strobe driven to the instruction memory `we` port.
- `cpu_hold`  out  1  stalls the fetch stage while high.
- `done`  out  1  image loaded and checksum correct.
- `error`  out  1  load aborted: length too large or checksum mismatch.

## Operation
- Stream format: `LEN_LO`, `LEN_HI`, then N word pairs (`lo`, `hi`), then one `CHK` byte.
  - N = {LEN_HI, LEN_LO}.
  - `CHK` must equal the XOR of every preceding byte of the load, including both length bytes.
- A byte is accepted when `in_valid & in_ready`. `in_ready` is 1 in states LEN_LO, LEN_HI, DAT_LO, DAT_HI and CHK, and 0 otherwise.
- States and transitions:
  - IDLE: `start` → LEN_LO.
  - LEN_LO: on accept → LEN_HI.
  - LEN_HI: on accept, N > MEM_WORDS → ERR; N = 0 → CHK; otherwise → DAT_LO.
  - DAT_LO: on accept → DAT_HI; the byte is stored as the low byte.
  - DAT_HI: on accept, issue a write of {hi, lo} to address `wcnt`, then increment `wcnt`. If `wcnt` was N-1 → CHK, otherwise → DAT_LO.
  - CHK: on accept, byte matches the running XOR → DONE; otherwise → ERR.
  - DONE / ERR: terminal. `start` clears `done`/`error`, `wcnt` and the XOR register, then → LEN_LO (reload).
- `start` is ignored in LEN_LO, LEN_HI, DAT_LO, DAT_HI and CHK.
- `wcnt` is ADDR_WIDTH wide and counts from 0. It never wraps, because N ≤ MEM_WORDS.
- `cpu_hold` = 1 in every state except DONE.
- Writes already made before an ERR are not undone. The instruction memory has no clear function.

## Timing
- Reset values: `in_ready`=0, `mem_addr`=0, `mem_data`=0, `mem_we`=0, `cpu_hold`=1, `done`=0, `error`=0. State = IDLE, `wcnt`=0, XOR=0.
- `mem_addr`, `mem_data` and `mem_we` are registered outputs.
  - `mem_we` is high for exactly one cycle, the cycle after the DAT_HI byte is accepted.
  - `mem_addr`/`mem_data` are valid during that cycle and hold their values afterwards.
  - The memory captures the word on the following rising edge.
- `in_ready` is a combinational decode of the state.
- Back-to-back bytes give one word per 2 cycles. Gaps in `in_valid` only stall; they never corrupt data.
- `done` rises, and `cpu_hold` falls, in the cycle after the CHK byte is accepted.
- `error` rises in the cycle after the failing byte is accepted.
- `rst` asserted at any point, including mid-word: all outputs return to reset values immediately. No further `mem_we` pulses occur, and the half-assembled word is discarded.

## Structure
- Shared package `imem_loader_pkg` holds:
  - state encoding (8 states, 3 bits);
  - header length (2 bytes) and checksum length (1 byte);
  - the 16-bit data/address width constants shared with the instruction memory and fetch stage.
- Single module. The byte assembler and XOR accumulator are a few registers each and are not worth a sub-module.

## Test plan
- Nominal load: reset, `start`, stream 02 00 34 12 CD AB 42 → writes 0x1234 at address 0 and 0xABCD at address 1, exactly 2 `mem_we` pulses; then `done`=1, `cpu_hold`=0, `error`=0.
- Bad checksum: same stream with 43 as the last byte → both writes occur, then `error`=1, `done`=0, `cpu_hold`=1.
- Oversize: `start`, 01 04 (N=1025, MEM_WORDS=1024) → `error`=1 the cycle after the second byte, `in_ready`=0, no `mem_we`.
- Backpressure/gaps: nominal stream with random 0–5-cycle `in_valid` gaps and a `start` pulse mid-load → identical writes and result; the mid-load `start` is ignored.
- Reset mid-word: assert `rst` right after the 34 byte is accepted → all outputs at reset values, no `mem_we`. A new `start` plus the full nominal stream succeeds.
- Empty image: `start`, 00 00 00 → `done`=1, no `mem_we`. A second `start` plus the nominal stream reloads successfully.
